fp_align_pipe: RTL and testbench

- Parametrised, pipelined successor to the FPU adder/subtractor exponent-compare block.
- Compares two unpacked operands by magnitude, selects the larger exponent, and right-shifts the smaller mantissa by the exponent difference with sticky collapse.
- Resolves the effective operation and result sign, and presents aligned operands to the mantissa add/normalise stage.
- Two-stage pipeline with valid/ready flow control and backpressure.

---
 rtl/fp_align_pipe.sv | 134 +++++++++++++
 tb/tb_fp_align_pipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fp_align_pipe.sv
// rtl/fp_align_pipe.sv - two-stage exponent compare and mantissa align pipeline
// Stage 1 compares magnitudes and clamps the shift; stage 2 shifts with sticky collapse.
module fp_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 28,
  parameter int SH_W  = $clog2(MAN_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic             a_sign,
  input  logic             b_sign,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [EXP_W-1:0] b_exp,
  input  logic [MAN_W-1:0] a_man,
  input  logic [MAN_W-1:0] b_man,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic             out_eff_sub,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man_max,
  output logic [MAN_W-1:0] out_man_aln,
  output logic             out_swap,
  output logic [SH_W-1:0]  out_shamt,
  output logic             out_zero
);

  logic             v1_q, v1_d, v2_q, v2_d;
  logic             s1_sign_q, s1_sign_d, s1_eff_q, s1_eff_d, s1_swap_q, s1_swap_d;
  logic             s1_zero_q, s1_zero_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic [MAN_W-1:0] s1_max_q, s1_max_d, s1_min_q, s1_min_d;
  logic [SH_W-1:0]  s1_shamt_q, s1_shamt_d;

  logic             s2_sign_q, s2_sign_d, s2_eff_q, s2_eff_d, s2_swap_q, s2_swap_d;
  logic             s2_zero_q, s2_zero_d;
  logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
  logic [MAN_W-1:0] s2_max_q, s2_max_d, s2_aln_q, s2_aln_d;
  logic [SH_W-1:0]  s2_shamt_q, s2_shamt_d;

  logic             s2_rdy, bs, eff, b_gt, sticky;
  logic [EXP_W-1:0] diff;
  logic [MAN_W-1:0] shifted;

  assign s2_rdy   = ~v2_q | out_ready;
  assign in_ready = ~v1_q | s2_rdy;

  always_comb begin
    bs   = b_sign ^ op_sub;
    eff  = a_sign ^ bs;
    b_gt = (b_exp > a_exp) || ((b_exp == a_exp) && (b_man > a_man));
    diff = b_gt ? (b_exp - a_exp) : (a_exp - b_exp);

    v1_d       = flush ? 1'b0 : (in_ready ? in_valid : v1_q);
    s1_sign_d  = s1_sign_q;
    s1_eff_d   = s1_eff_q;
    s1_swap_d  = s1_swap_q;
    s1_zero_d  = s1_zero_q;
    s1_exp_d   = s1_exp_q;
    s1_max_d   = s1_max_q;
    s1_min_d   = s1_min_q;
    s1_shamt_d = s1_shamt_q;
    if (in_valid && in_ready) begin
      s1_swap_d  = b_gt;
      s1_sign_d  = b_gt ? bs : a_sign;
      s1_eff_d   = eff;
      s1_exp_d   = b_gt ? b_exp : a_exp;
      s1_max_d   = b_gt ? b_man : a_man;
      s1_min_d   = b_gt ? a_man : b_man;
      s1_shamt_d = (diff >= EXP_W'(MAN_W)) ? SH_W'(MAN_W) : SH_W'(diff);
      s1_zero_d  = eff && (a_exp == b_exp) && (a_man == b_man);
    end
  end

  // Sticky collects every bit that falls below the LSB; a full-width shift leaves only sticky.
  always_comb begin
    sticky = 1'b0;
    for (int i = 0; i < MAN_W; i++) begin
      if (i < int'(s1_shamt_q)) sticky = sticky | s1_min_q[i];
    end
    shifted = s1_min_q >> s1_shamt_q;

    v2_d       = flush ? 1'b0 : (s2_rdy ? v1_q : v2_q);
    s2_sign_d  = s2_sign_q;
    s2_eff_d   = s2_eff_q;
    s2_swap_d  = s2_swap_q;
    s2_zero_d  = s2_zero_q;
    s2_exp_d   = s2_exp_q;
    s2_max_d   = s2_max_q;
    s2_aln_d   = s2_aln_q;
    s2_shamt_d = s2_shamt_q;
    if (v1_q && s2_rdy) begin
      s2_sign_d  = s1_sign_q;
      s2_eff_d   = s1_eff_q;
      s2_swap_d  = s1_swap_q;
      s2_zero_d  = s1_zero_q;
      s2_exp_d   = s1_exp_q;
      s2_max_d   = s1_max_q;
      s2_aln_d   = {shifted[MAN_W-1:1], shifted[0] | sticky};
      s2_shamt_d = s1_shamt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; v2_q <= 1'b0;
      s1_sign_q <= 1'b0; s1_eff_q <= 1'b0; s1_swap_q <= 1'b0; s1_zero_q <= 1'b0;
      s1_exp_q <= '0; s1_max_q <= '0; s1_min_q <= '0; s1_shamt_q <= '0;
      s2_sign_q <= 1'b0; s2_eff_q <= 1'b0; s2_swap_q <= 1'b0; s2_zero_q <= 1'b0;
      s2_exp_q <= '0; s2_max_q <= '0; s2_aln_q <= '0; s2_shamt_q <= '0;
    end else begin
      v1_q <= v1_d; v2_q <= v2_d;
      s1_sign_q <= s1_sign_d; s1_eff_q <= s1_eff_d; s1_swap_q <= s1_swap_d; s1_zero_q <= s1_zero_d;
      s1_exp_q <= s1_exp_d; s1_max_q <= s1_max_d; s1_min_q <= s1_min_d; s1_shamt_q <= s1_shamt_d;
      s2_sign_q <= s2_sign_d; s2_eff_q <= s2_eff_d; s2_swap_q <= s2_swap_d; s2_zero_q <= s2_zero_d;
      s2_exp_q <= s2_exp_d; s2_max_q <= s2_max_d; s2_aln_q <= s2_aln_d; s2_shamt_q <= s2_shamt_d;
    end
  end

  assign out_valid   = v2_q;
  assign out_sign    = s2_sign_q;
  assign out_eff_sub = s2_eff_q;
  assign out_exp     = s2_exp_q;
  assign out_man_max = s2_max_q;
  assign out_man_aln = s2_aln_q;
  assign out_swap    = s2_swap_q;
  assign out_shamt   = s2_shamt_q;
  assign out_zero    = s2_zero_q;

endmodule

// File: tb/tb_fp_align_pipe.sv
// tb/tb_fp_align_pipe.sv - directed vector bench for fp_align_pipe
module tb_fp_align_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, op_sub, a_sign, b_sign;
  logic [7:0]  a_exp, b_exp, out_exp;
  logic [27:0] a_man, b_man, out_man_max, out_man_aln;
  logic        out_valid, out_ready, out_sign, out_eff_sub, out_swap, out_zero;
  logic [4:0]  out_shamt;

  int checks = 0;
  int errors = 0;

  fp_align_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
    .a_man(a_man), .b_man(b_man), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_eff_sub(out_eff_sub), .out_exp(out_exp),
    .out_man_max(out_man_max), .out_man_aln(out_man_aln), .out_swap(out_swap),
    .out_shamt(out_shamt), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        a_sign, b_sign, op_sub;
    logic [7:0]  a_exp, b_exp;
    logic [27:0] a_man, b_man;
    logic        sign, eff_sub, swap, zero;
    logic [7:0]  exp;
    logic [27:0] man_max, man_aln;
    logic [4:0]  shamt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i);
    a_sign = vecs[i].a_sign; b_sign = vecs[i].b_sign; op_sub = vecs[i].op_sub;
    a_exp = vecs[i].a_exp; b_exp = vecs[i].b_exp; a_man = vecs[i].a_man; b_man = vecs[i].b_man;
  endtask

  initial begin
    //           as    bs    sub   aexp   bexp   aman          bman          sign  eff   swap  zero  exp    max           aln           sh
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h80, 8'h7E, 28'h8000000, 28'hC000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 28'h8000000, 28'h3000000, 5'd2};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h90, 8'h90, 28'h8000001, 28'h8000001, 1'b0, 1'b1, 1'b0, 1'b1, 8'h90, 28'h8000001, 28'h8000001, 5'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 8'hA8, 8'h80, 28'h8000000, 28'h8000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA8, 28'h8000000, 28'h0000001, 5'd28};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h80, 8'h81, 28'h8000001, 28'h8000000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h81, 28'h8000000, 28'h4000001, 5'd1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h70, 8'h70, 28'h9000000, 28'hA000000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h70, 28'hA000000, 28'h9000000, 5'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h9C, 8'h80, 28'h8000000, 28'h0000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h9C, 28'h8000000, 28'h0000000, 5'd28};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 8'h83, 8'h80, 28'hC000000, 28'h4000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h83, 28'hC000000, 28'h0800000, 5'd3};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_vec(0);
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_man_aln", 32'(out_man_aln), 0);
    chk("reset_exp", 32'(out_exp), 0);
    rst_n = 1'b1;
    #1 chk("reset_in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 7; i++) begin
      int lat;
      @(negedge clk);
      set_vec(i); in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("v%0d_latency", i), 32'(lat), 2);
      chk($sformatf("v%0d_sign", i), 32'(out_sign), 32'(vecs[i].sign));
      chk($sformatf("v%0d_eff_sub", i), 32'(out_eff_sub), 32'(vecs[i].eff_sub));
      chk($sformatf("v%0d_swap", i), 32'(out_swap), 32'(vecs[i].swap));
      chk($sformatf("v%0d_zero", i), 32'(out_zero), 32'(vecs[i].zero));
      chk($sformatf("v%0d_exp", i), 32'(out_exp), 32'(vecs[i].exp));
      chk($sformatf("v%0d_man_max", i), 32'(out_man_max), 32'(vecs[i].man_max));
      chk($sformatf("v%0d_man_aln", i), 32'(out_man_aln), 32'(vecs[i].man_aln));
      chk($sformatf("v%0d_shamt", i), 32'(out_shamt), 32'(vecs[i].shamt));
    end

    // Stream of 4 with a 3-cycle downstream stall; item k has shift k
    begin
      int tx = 0, rx = 0, cyc = 0;
      logic saw_stall = 1'b0, held = 1'b0;
      logic [7:0]  h_exp;
      logic [27:0] h_aln;
      @(negedge clk);
      while (rx < 4 && cyc < 40) begin
        out_ready = !(cyc >= 2 && cyc <= 4);
        in_valid  = (tx < 4);
        a_sign = 1'b0; b_sign = 1'b0; op_sub = 1'b0;
        a_exp = 8'h80 + 8'(tx); b_exp = 8'h80; a_man = 28'h8000000; b_man = 28'h8000000;
        #1;
        if (held) begin
          chk("stream_hold_valid", 32'(out_valid), 1);
          chk("stream_hold_exp", 32'(out_exp), 32'(h_exp));
          chk("stream_hold_aln", 32'(out_man_aln), 32'(h_aln));
        end
        held = out_valid && !out_ready;
        h_exp = out_exp; h_aln = out_man_aln;
        if (!in_ready) saw_stall = 1'b1;
        if (out_valid && out_ready) begin
          chk($sformatf("stream%0d_exp", rx), 32'(out_exp), 32'h80 + 32'(rx));
          chk($sformatf("stream%0d_aln", rx), 32'(out_man_aln), 32'h8000000 >> rx);
          chk($sformatf("stream%0d_shamt", rx), 32'(out_shamt), 32'(rx));
          rx++;
        end
        if (in_valid && in_ready) tx++;
        @(negedge clk);
        cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("stream_received", 32'(rx), 4);
      chk("stream_in_ready_dropped", 32'(saw_stall), 1);
      #1 chk("stream_drained", 32'(out_valid), 0);
    end

    // Async reset with both stages full
    @(negedge clk);
    out_ready = 1'b0; set_vec(0); in_valid = 1'b1;
    @(negedge clk);
    set_vec(3);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_pre_full", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 0);
    chk("rst_mid_man_max", 32'(out_man_max), 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("rst_release_in_ready", 32'(in_ready), 1);
    begin
      logic seen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      chk("rst_no_stale_output", 32'(seen), 0);
    end

    // Flush beats a simultaneous accept
    @(negedge clk);
    set_vec(2); in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    begin
      logic seen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      chk("flush_drops_accept", 32'(seen), 0);
    end

    // Flush clears a stalled output stage
    @(negedge clk);
    out_ready = 1'b0; set_vec(4); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_pre_valid", 32'(out_valid), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_clears_v2", 32'(out_valid), 0);
    out_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
